// File: rtl/pcap_replay_arbiter_pkg.sv
// Shared constants for the pcap replay arbiter: tuser field layout,
// one-hot MAC port encodings and FSM state encodings.
package pcap_replay_arbiter_pkg;

    localparam int TUSER_LEN_OFF = 0;
    localparam int TUSER_SRC_OFF = 16;
    localparam int TUSER_DST_OFF = 24;
    localparam int TUSER_DST_W   = 8;

    localparam logic [TUSER_DST_W-1:0] PORT_ONEHOT_Q0 = 8'h01;
    localparam logic [TUSER_DST_W-1:0] PORT_ONEHOT_Q1 = 8'h04;
    localparam logic [TUSER_DST_W-1:0] PORT_ONEHOT_Q2 = 8'h10;
    localparam logic [TUSER_DST_W-1:0] PORT_ONEHOT_Q3 = 8'h40;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    // Replay queue i drives MAC port i, which sits at bit 2*i of the dst field.
    function automatic logic [TUSER_DST_W-1:0] dst_onehot(input logic [1:0] q);
        case (q)
            2'd0:    return PORT_ONEHOT_Q0;
            2'd1:    return PORT_ONEHOT_Q1;
            2'd2:    return PORT_ONEHOT_Q2;
            default: return PORT_ONEHOT_Q3;
        endcase
    endfunction

endpackage

// File: rtl/pcap_replay_arbiter_rr_grant_sel.sv
// Combinational round-robin picker: first requester searching upward
// from last_grant+1, wrapping modulo the queue count.
module rr_grant_sel #(
    parameter int NUM_QUEUES = 4
) (
    input  logic [NUM_QUEUES-1:0] req_i,
    input  logic [1:0]            last_grant_i,
    output logic [1:0]            grant_o,
    output logic                  grant_valid_o
);

    // Walk the offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        for (int k = NUM_QUEUES; k >= 1; k--) begin
            if (req_i[last_grant_i + 2'(k)]) begin
                grant_o       = last_grant_i + 2'(k);
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcap_replay_arbiter.sv
// Merges four replay streams into one AXI-Stream toward the MAC ports.
// Packet-atomic round-robin with one arbitration cycle per packet;
// rewrites the tuser dst byte to the port owned by the granted queue.
//
// state   | meaning
// ST_ARB  | no grant held; pick next eligible queue (outputs idle)
// ST_XFER | granted queue wired through until its tlast handshake
module pcap_replay_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES         = 4
) (
    input  logic                            axis_aclk,
    input  logic                            axis_reset,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
    input  logic                            s0_axis_tvalid,
    output logic                            s0_axis_tready,
    input  logic                            s0_axis_tlast,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
    input  logic                            s1_axis_tvalid,
    output logic                            s1_axis_tready,
    input  logic                            s1_axis_tlast,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s2_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s2_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s2_axis_tuser,
    input  logic                            s2_axis_tvalid,
    output logic                            s2_axis_tready,
    input  logic                            s2_axis_tlast,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s3_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s3_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s3_axis_tuser,
    input  logic                            s3_axis_tvalid,
    output logic                            s3_axis_tready,
    input  logic                            s3_axis_tlast,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,

    input  logic [NUM_QUEUES-1:0]           q_enable,
    input  logic                            cnt_clear,
    output logic [32*NUM_QUEUES-1:0]        pkt_cnt,
    output logic                            busy
);

    import pcap_replay_arbiter_pkg::*;

    arb_state_e                         state_q, state_d;
    logic [1:0]                         grant_q, grant_d;
    logic [1:0]                         last_grant_q, last_grant_d;
    logic [NUM_QUEUES-1:0][31:0]        pkt_cnt_q, pkt_cnt_d;

    logic [C_AXIS_DATA_WIDTH-1:0]       g_tdata;
    logic [C_AXIS_DATA_WIDTH/8-1:0]     g_tkeep;
    logic [C_AXIS_TUSER_WIDTH-1:0]      g_tuser;
    logic                               g_tvalid;
    logic                               g_tlast;

    logic [NUM_QUEUES-1:0]              s_tvalid_vec;
    logic [NUM_QUEUES-1:0]              s_tready_vec;
    logic [NUM_QUEUES-1:0]              eligible;
    logic [1:0]                         sel_grant;
    logic                               sel_valid;
    logic                               xfer_act;
    logic                               last_hs;

    assign s_tvalid_vec = {s3_axis_tvalid, s2_axis_tvalid, s1_axis_tvalid, s0_axis_tvalid};
    assign eligible     = s_tvalid_vec & q_enable;

    rr_grant_sel #(
        .NUM_QUEUES (NUM_QUEUES)
    ) u_rr_grant_sel (
        .req_i         (eligible),
        .last_grant_i  (last_grant_q),
        .grant_o       (sel_grant),
        .grant_valid_o (sel_valid)
    );

    // Select the granted stream's payload.
    always_comb begin
        g_tdata  = s0_axis_tdata;
        g_tkeep  = s0_axis_tkeep;
        g_tuser  = s0_axis_tuser;
        g_tvalid = s0_axis_tvalid;
        g_tlast  = s0_axis_tlast;
        case (grant_q)
            2'd1: begin
                g_tdata  = s1_axis_tdata;
                g_tkeep  = s1_axis_tkeep;
                g_tuser  = s1_axis_tuser;
                g_tvalid = s1_axis_tvalid;
                g_tlast  = s1_axis_tlast;
            end
            2'd2: begin
                g_tdata  = s2_axis_tdata;
                g_tkeep  = s2_axis_tkeep;
                g_tuser  = s2_axis_tuser;
                g_tvalid = s2_axis_tvalid;
                g_tlast  = s2_axis_tlast;
            end
            2'd3: begin
                g_tdata  = s3_axis_tdata;
                g_tkeep  = s3_axis_tkeep;
                g_tuser  = s3_axis_tuser;
                g_tvalid = s3_axis_tvalid;
                g_tlast  = s3_axis_tlast;
            end
            default: ;
        endcase
    end

    // Reset gates the handshake so nothing moves while the FSM is being cleared.
    assign xfer_act      = (state_q == ST_XFER) && !axis_reset;
    assign busy          = xfer_act;
    assign m_axis_tvalid = xfer_act && g_tvalid;
    assign m_axis_tdata  = g_tdata;
    assign m_axis_tkeep  = g_tkeep;
    assign m_axis_tlast  = g_tlast;
    assign last_hs       = xfer_act && g_tvalid && m_axis_tready && g_tlast;

    // Pass tuser through with the dst byte replaced by the granted queue's port.
    always_comb begin
        m_axis_tuser = g_tuser;
        m_axis_tuser[TUSER_DST_OFF +: TUSER_DST_W] = dst_onehot(grant_q);
    end

    // Backpressure reaches only the granted queue.
    always_comb begin
        s_tready_vec = '0;
        if (xfer_act) begin
            s_tready_vec[grant_q] = m_axis_tready;
        end
    end

    assign s0_axis_tready = s_tready_vec[0];
    assign s1_axis_tready = s_tready_vec[1];
    assign s2_axis_tready = s_tready_vec[2];
    assign s3_axis_tready = s_tready_vec[3];

    // Next state: grant on any eligible queue, release on the tlast handshake.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_ARB: begin
                if (sel_valid) begin
                    grant_d = sel_grant;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (last_hs) begin
                    last_grant_d = grant_q;
                    state_d      = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Per-queue packet counters; a clear pulse overrides a coincident increment.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (cnt_clear) begin
            pkt_cnt_d = '0;
        end else if (last_hs) begin
            pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + 32'd1;
        end
    end

    assign pkt_cnt = pkt_cnt_q;

    // State, grant and counter registers; last_grant resets so queue 0 wins first.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q      <= ST_ARB;
            grant_q      <= '0;
            last_grant_q <= 2'(NUM_QUEUES - 1);
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

endmodule

// File: tb/tb_pcap_replay_arbiter.sv
// Self-checking bench for pcap_replay_arbiter: queue-backed sources,
// a scoreboard of expected output beats, a table of arbitration vectors
// and hand-written sequences for the multi-cycle corner cases.
module tb_pcap_replay_arbiter;
    import pcap_replay_arbiter_pkg::*;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic [127:0] user;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic [3:0]      en;
        logic [3:0]      loaded;
        int              len;
        int              n_exp;
        logic [3:0][1:0] order;
    } vec_t;

    localparam logic [7:0] DST_TBL [4] = '{8'h01, 8'h04, 8'h10, 8'h40};

    logic         clk;
    logic         axis_reset;
    logic [255:0] s_tdata [4];
    logic [31:0]  s_tkeep [4];
    logic [127:0] s_tuser [4];
    logic [3:0]   s_tvalid;
    logic [3:0]   s_tlast;
    wire  [3:0]   s_tready;
    wire  [255:0] m_tdata;
    wire  [31:0]  m_tkeep;
    wire  [127:0] m_tuser;
    wire          m_tvalid;
    wire          m_tlast;
    logic         m_tready;
    logic [3:0]   q_enable;
    logic         cnt_clear;
    wire  [127:0] pkt_cnt;
    wire          busy;

    beat_t       src_q [4][$];
    beat_t       sb [$];
    logic [31:0] cnt_m [4];
    logic [3:0]  hs;
    logic [3:0]  watch_mask;
    int          checks = 0;
    int          failures = 0;
    int          out_beats = 0;
    int          busy_cycles = 0;
    int          ready_viol = 0;
    int          tag = 0;
    vec_t        vt [6];

    pcap_replay_arbiter dut (
        .axis_aclk      (clk),
        .axis_reset     (axis_reset),
        .s0_axis_tdata  (s_tdata[0]), .s0_axis_tkeep (s_tkeep[0]), .s0_axis_tuser (s_tuser[0]),
        .s0_axis_tvalid (s_tvalid[0]), .s0_axis_tready (s_tready[0]), .s0_axis_tlast (s_tlast[0]),
        .s1_axis_tdata  (s_tdata[1]), .s1_axis_tkeep (s_tkeep[1]), .s1_axis_tuser (s_tuser[1]),
        .s1_axis_tvalid (s_tvalid[1]), .s1_axis_tready (s_tready[1]), .s1_axis_tlast (s_tlast[1]),
        .s2_axis_tdata  (s_tdata[2]), .s2_axis_tkeep (s_tkeep[2]), .s2_axis_tuser (s_tuser[2]),
        .s2_axis_tvalid (s_tvalid[2]), .s2_axis_tready (s_tready[2]), .s2_axis_tlast (s_tlast[2]),
        .s3_axis_tdata  (s_tdata[3]), .s3_axis_tkeep (s_tkeep[3]), .s3_axis_tuser (s_tuser[3]),
        .s3_axis_tvalid (s_tvalid[3]), .s3_axis_tready (s_tready[3]), .s3_axis_tlast (s_tlast[3]),
        .m_axis_tdata   (m_tdata),
        .m_axis_tkeep   (m_tkeep),
        .m_axis_tuser   (m_tuser),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .m_axis_tlast   (m_tlast),
        .q_enable       (q_enable),
        .cnt_clear      (cnt_clear),
        .pkt_cnt        (pkt_cnt),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim_time=%0t limit=200000", $time);
        $fatal(1, "watchdog");
    end

    function automatic beat_t mk_beat(int q, int len, int t, int b, bit exp_side);
        beat_t bt;
        bt.data = {8{{8'(q), 8'(t), 16'(b)}}};
        bt.keep = (b == len - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        bt.user = '0;
        bt.user[127:32] = {3{32'hC0DE_0000 | 32'(t)}};
        bt.user[TUSER_LEN_OFF +: 16] = 16'(len * 32);
        bt.user[TUSER_SRC_OFF +: 8]  = 8'(q);
        bt.user[TUSER_DST_OFF +: 8]  = exp_side ? DST_TBL[q] : 8'h5A;
        bt.last = (b == len - 1);
        return bt;
    endfunction

    task automatic load_pkt(int q, int len, int t);
        for (int b = 0; b < len; b++) src_q[q].push_back(mk_beat(q, len, t, b, 1'b0));
    endtask

    task automatic expect_pkt(int q, int len, int t);
        for (int b = 0; b < len; b++) sb.push_back(mk_beat(q, len, t, b, 1'b1));
        cnt_m[q] = cnt_m[q] + 32'd1;
    endtask

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic check_cnts(string name);
        for (int i = 0; i < 4; i++)
            check32($sformatf("%s_cnt%0d", name, i), pkt_cnt[32*i +: 32], cnt_m[i]);
    endtask

    task automatic wait_drain(string name, int max);
        int n = 0;
        while (n < max) begin
            @(negedge clk); #3;
            if (sb.size() == 0 && !busy) break;
            n++;
        end
        checks++;
        if (n >= max) begin
            failures++;
            $display("FAIL %s_drain_timeout left=%0d want=0", name, sb.size());
        end
    endtask

    task automatic wait_beats(string name, int nb, int max);
        int base = out_beats;
        int c = 0;
        while (out_beats < base + nb && c < max) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (out_beats < base + nb) begin
            failures++;
            $display("FAIL %s_beat_timeout got=%0d want=%0d", name, out_beats - base, nb);
        end
    endtask

    task automatic flush_sources();
        for (int i = 0; i < 4; i++) src_q[i].delete();
        repeat (2) @(negedge clk);
    endtask

    // Source driver: pop on the handshake seen in the previous cycle, present the next beat.
    initial begin
        hs = '0;
        forever begin
            @(negedge clk); #2;
            hs = s_tvalid & s_tready;
        end
    end

    initial begin
        s_tvalid = '0;
        s_tlast  = '0;
        for (int i = 0; i < 4; i++) begin
            s_tdata[i] = '0;
            s_tkeep[i] = '0;
            s_tuser[i] = '0;
        end
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    s_tvalid[i] = 1'b1;
                    s_tdata[i]  = src_q[i][0].data;
                    s_tkeep[i]  = src_q[i][0].keep;
                    s_tuser[i]  = src_q[i][0].user;
                    s_tlast[i]  = src_q[i][0].last;
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                end
            end
        end
    end

    // Output monitor: every accepted beat must be the next scoreboard entry.
    initial begin
        beat_t act, exp;
        forever begin
            @(negedge clk); #2;
            if (busy) busy_cycles++;
            if ((s_tready & watch_mask) != 4'b0) ready_viol++;
            if ($countones(s_tready) > 1) ready_viol++;
            if (m_tvalid && m_tready) begin
                out_beats++;
                checks++;
                act.data = m_tdata;
                act.keep = m_tkeep;
                act.user = m_tuser;
                act.last = m_tlast;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat got data=%h user=%h want none", act.data[31:0], act.user[31:0]);
                end else begin
                    exp = sb.pop_front();
                    if (act !== exp) begin
                        failures++;
                        $display("FAIL beat%0d got data=%h keep=%h user=%h last=%b want data=%h keep=%h user=%h last=%b",
                                 out_beats, act.data[31:0], act.keep, act.user[31:0], act.last,
                                 exp.data[31:0], exp.keep, exp.user[31:0], exp.last);
                    end
                end
            end
        end
    end

    initial begin
        int base;
        int n;
        vt[0] = '{en: 4'b1111, loaded: 4'b1111, len: 3, n_exp: 4, order: {2'd3, 2'd2, 2'd1, 2'd0}};
        vt[1] = '{en: 4'b1111, loaded: 4'b0110, len: 2, n_exp: 2, order: {2'd0, 2'd0, 2'd2, 2'd1}};
        vt[2] = '{en: 4'b1111, loaded: 4'b1011, len: 2, n_exp: 3, order: {2'd0, 2'd1, 2'd0, 2'd3}};
        vt[3] = '{en: 4'b0101, loaded: 4'b1111, len: 1, n_exp: 2, order: {2'd0, 2'd0, 2'd0, 2'd2}};
        vt[4] = '{en: 4'b1111, loaded: 4'b1001, len: 2, n_exp: 2, order: {2'd0, 2'd0, 2'd0, 2'd3}};
        vt[5] = '{en: 4'b1010, loaded: 4'b1111, len: 2, n_exp: 2, order: {2'd0, 2'd0, 2'd3, 2'd1}};

        axis_reset = 1'b1;
        q_enable   = '0;
        cnt_clear  = 1'b0;
        m_tready   = 1'b1;
        watch_mask = '0;
        for (int i = 0; i < 4; i++) cnt_m[i] = '0;

        // Reset: outputs idle during and after reset, counters zero.
        repeat (2) @(negedge clk);
        #1;
        check32("rst_during_tvalid", 32'(m_tvalid), 32'd0);
        check32("rst_during_busy", 32'(busy), 32'd0);
        check32("rst_during_tready", 32'(s_tready), 32'd0);
        @(negedge clk);
        axis_reset = 1'b0;
        #1;
        check32("rst_after_tvalid", 32'(m_tvalid), 32'd0);
        check32("rst_after_busy", 32'(busy), 32'd0);
        check_cnts("rst");

        // Table of arbitration patterns; round-robin pointer carries across vectors.
        for (int v = 0; v < 6; v++) begin
            int bc0;
            @(negedge clk);
            q_enable = vt[v].en;
            for (int q = 0; q < 4; q++)
                if (vt[v].loaded[q]) load_pkt(q, vt[v].len, tag + q);
            for (int k = 0; k < vt[v].n_exp; k++)
                expect_pkt(int'(vt[v].order[k]), vt[v].len, tag + int'(vt[v].order[k]));
            bc0 = busy_cycles;
            wait_drain($sformatf("vec%0d", v), 80);
            if (v == 0) check32("vec0_busy_cycles", 32'(busy_cycles - bc0), 32'd12);
            flush_sources();
            check_cnts($sformatf("vec%0d", v));
            tag += 4;
        end

        // Only q1/q3 enabled with q0/q2 also valid: strict q1,q3 alternation.
        @(negedge clk);
        q_enable   = 4'b1010;
        watch_mask = 4'b0101;
        load_pkt(0, 2, tag);
        load_pkt(2, 2, tag + 1);
        for (int p = 0; p < 3; p++) begin
            load_pkt(1, 2, tag + 2 + 2 * p);
            load_pkt(3, 2, tag + 3 + 2 * p);
        end
        for (int p = 0; p < 3; p++) begin
            expect_pkt(1, 2, tag + 2 + 2 * p);
            expect_pkt(3, 2, tag + 3 + 2 * p);
        end
        wait_drain("alt", 120);
        flush_sources();
        watch_mask = '0;
        check32("alt_ready_viol", 32'(ready_viol), 32'd0);
        check_cnts("alt");
        tag += 8;

        // Toggling m_axis_tready across a 4-beat q2 packet.
        q_enable = 4'b1111;
        load_pkt(2, 4, tag);
        expect_pkt(2, 4, tag);
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            m_tready = ~m_tready;
            #3;
            if (sb.size() == 0 && !busy) break;
            n++;
        end
        check32("bp_timeout", 32'(n >= 60), 32'd0);
        @(negedge clk);
        m_tready = 1'b1;
        flush_sources();
        check_cnts("bp");
        tag += 1;

        // q_enable[0] dropped mid-packet: packet completes, second q0 packet skipped.
        load_pkt(0, 5, tag);
        load_pkt(0, 2, tag + 1);
        load_pkt(1, 2, tag + 2);
        expect_pkt(0, 5, tag);
        expect_pkt(1, 2, tag + 2);
        wait_beats("dis", 2, 40);
        q_enable = 4'b1110;
        wait_drain("dis", 60);
        repeat (10) @(negedge clk);
        #3;
        check32("dis_busy_idle", 32'(busy), 32'd0);
        flush_sources();
        check_cnts("dis");
        q_enable = 4'b1111;
        tag += 3;

        // Counter wrap on q0, then clear coincident with a tlast handshake.
        force dut.pkt_cnt_q = {cnt_m[3], cnt_m[2], cnt_m[1], 32'hFFFF_FFFF};
        @(posedge clk);
        @(negedge clk);
        release dut.pkt_cnt_q;
        cnt_m[0] = 32'hFFFF_FFFF;
        #1;
        check32("wrap_preload", pkt_cnt[31:0], 32'hFFFF_FFFF);
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            load_pkt(0, 2, tag + p);
            expect_pkt(0, 2, tag + p);
            wait_drain($sformatf("wrap%0d", p), 40);
            check32($sformatf("wrap%0d_cnt0", p), pkt_cnt[31:0], 32'(p));
        end
        tag += 2;
        @(negedge clk);
        m_tready = 1'b0;
        load_pkt(0, 1, tag);
        expect_pkt(0, 1, tag);
        n = 0;
        while (n < 40) begin
            @(negedge clk); #3;
            if (busy && m_tvalid) break;
            n++;
        end
        check32("clr_grant_timeout", 32'(n >= 40), 32'd0);
        @(negedge clk);
        m_tready  = 1'b1;
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        for (int i = 0; i < 4; i++) cnt_m[i] = '0;
        wait_drain("clr", 20);
        check_cnts("clr");
        tag += 1;

        // Reset in the middle of a q1 packet, then arbitration restarts at q0.
        load_pkt(1, 4, tag);
        expect_pkt(1, 4, tag);
        wait_beats("rstmid", 2, 40);
        axis_reset = 1'b1;
        for (int i = 0; i < 4; i++) src_q[i].delete();
        sb.delete();
        #1;
        check32("rstmid_during_tvalid", 32'(m_tvalid), 32'd0);
        check32("rstmid_during_tready", 32'(s_tready), 32'd0);
        @(negedge clk);
        axis_reset = 1'b0;
        for (int i = 0; i < 4; i++) cnt_m[i] = '0;
        #1;
        check32("rstmid_after_tvalid", 32'(m_tvalid), 32'd0);
        check32("rstmid_after_busy", 32'(busy), 32'd0);
        check_cnts("rstmid");
        @(negedge clk);
        load_pkt(1, 2, tag + 1);
        load_pkt(0, 2, tag + 2);
        expect_pkt(0, 2, tag + 2);
        expect_pkt(1, 2, tag + 1);
        wait_drain("post_rst", 40);
        check_cnts("post_rst");

        base = out_beats;
        repeat (3) @(negedge clk);
        check32("final_no_extra_beats", 32'(out_beats - base), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcap_replay_arbiter.md
PCAP_REPLAY_ARBITER -- requirements
Module: pcap_replay_arbiter

Interface
REQ-001 Parameter C_AXIS_DATA_WIDTH, default 256, tdata width of every stream.
REQ-002 Parameter C_AXIS_TUSER_WIDTH, default 128, tuser width of every stream.
REQ-003 Parameter NUM_QUEUES, default 4, number of replay input streams (fixed at 4 in this revision).
REQ-004 axis_aclk  in  1  single clock; all logic on its rising edge.
REQ-005 axis_reset  in  1  reset, synchronous, active-high.
REQ-006 s<i>_axis_tdata  in  C_AXIS_DATA_WIDTH  replay stream i (i=0..3) data, read back from external memory.
REQ-007 s<i>_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  stream i byte enables.
REQ-008 s<i>_axis_tuser  in  C_AXIS_TUSER_WIDTH  stream i sideband (NetFPGA layout: len [15:0], src [23:16], dst [31:24]).
REQ-009 s<i>_axis_tvalid  in  1  stream i valid.
REQ-010 s<i>_axis_tready  out  1  stream i ready.
REQ-011 s<i>_axis_tlast  in  1  stream i end of packet.
REQ-012 m_axis_tdata/tkeep/tuser/tvalid/tlast  out  as s<i>  merged output toward the MAC ports; m_axis_tready  in  1.
REQ-013 q_enable  in  NUM_QUEUES  per-queue replay enable from the register block.
REQ-014 cnt_clear  in  1  one-cycle pulse that clears all packet counters.
REQ-015 pkt_cnt  out  32*NUM_QUEUES  per-queue transmitted-packet counters, queue i at [32*i+:32].
REQ-016 busy  out  1  high while a packet is being transferred (state XFER).

Function
REQ-017 States: ARB, XFER; state register and grant index (2 bits) and last_grant (2 bits) are registered.
REQ-018 ARB: queue i is eligible when s<i>_axis_tvalid and q_enable[i]; no eligible queue -> remain in ARB.
REQ-019 ARB selection: round-robin, first eligible index searching upward from last_grant+1 modulo NUM_QUEUES; grant registered; next state XFER.
REQ-020 ARB outputs: m_axis_tvalid=0, all s<i>_axis_tready=0; one arbitration bubble cycle per packet.
REQ-021 XFER: m_axis_tdata/tkeep/tlast and tvalid are combinational copies of the granted queue; s<grant>_axis_tready = m_axis_tready; all other s<i>_axis_tready=0.
REQ-022 XFER: m_axis_tuser = granted tuser with [31:24] overwritten by one-hot dst 8'h01<<(2*grant) (queue 0->8'h01, 1->8'h04, 2->8'h10, 3->8'h40); all other bits passed unchanged.
REQ-023 Grant is packet-atomic: no switch until the beat with m_axis_tvalid & m_axis_tready & m_axis_tlast; then last_grant<=grant, next state ARB.
REQ-024 q_enable[grant] deasserted mid-packet: current packet completes; queue not eligible at next ARB.
REQ-025 Granted tvalid low mid-packet: stay in XFER, m_axis_tvalid=0, no timeout.
REQ-026 pkt_cnt[i] increments by 1 on each tlast handshake of queue i; wraps 32'hFFFFFFFF -> 0.
REQ-027 cnt_clear and increment in same cycle: clear wins, counter = 0.
REQ-028 Throughput: back-to-back beats within a packet at one beat/cycle when m_axis_tready held high.

Reset
REQ-029 axis_reset high at a clock edge: state<=ARB, grant<=0, last_grant<=NUM_QUEUES-1 (queue 0 wins first), all pkt_cnt<=0.
REQ-030 During and immediately after reset: m_axis_tvalid=0, all s<i>_axis_tready=0, busy=0; reset mid-packet truncates the packet with no tlast emitted.

Structure
REQ-031 Shared package holds the tuser field offsets (len 0, src 16, dst 24), port one-hot encoding constants and the state encodings.
REQ-032 One sub-module, rr_grant_sel: combinational round-robin picker (request vector, last_grant -> grant index, grant_valid).

Verification
REQ-033 Reset, all queues enabled, q0..q3 each hold one 3-beat packet -> output order q0,q1,q2,q3; dst bytes 01,04,10,40; pkt_cnt each 1.
REQ-034 q1 and q3 continuously valid, q_enable=4'b1010 -> strict alternation q1,q3,q1,...; q0/q2 tready always 0.
REQ-035 m_axis_tready toggled 1,0 per cycle during 4-beat packet on q2 -> beats delivered in order unchanged, no duplication, pkt_cnt[2]=1.
REQ-036 q_enable[0] cleared on beat 2 of 5-beat q0 packet -> all 5 beats delivered, q0 then skipped.
REQ-037 pkt_cnt[0] forced near 32'hFFFFFFFF, two q0 packets -> reads 0 then 1; cnt_clear coincident with tlast -> 0.
REQ-038 axis_reset asserted mid-packet on q1 -> next cycle tvalid=0, counters 0, following packet arbitrated from q0.
